line_word_serializer: RTL and testbench

LINE_WORD_SERIALIZER -- requirements
Module: line_word_serializer

---
 rtl/line_word_serializer_pkg.sv | 13 +
 rtl/line_word_serializer_select.sv | 20 ++
 rtl/line_word_serializer.sv | 96 +++++++++
 tb/tb_line_word_serializer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/line_word_serializer_pkg.sv
// Shared LC-3b line/word types and the serializer state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [2:0]   lc3b_line_offset;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } ser_state_e;

endpackage

// File: rtl/line_word_serializer_select.sv
// Combinational word selector: returns word idx of a WORD_WIDTH-sliced line.
module line_word_select #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH = 16,
  localparam int unsigned WORDS     = LINE_WIDTH / WORD_WIDTH,
  localparam int unsigned IDXW      = $clog2(WORDS)
) (
  input  logic [LINE_WIDTH-1:0] line,
  input  logic [IDXW-1:0]       idx,
  output logic [WORD_WIDTH-1:0] word
);

  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (idx == IDXW'(k)) word = line[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

endmodule

// File: rtl/line_word_serializer.sv
// Serializes a registered cache line into WORD_WIDTH beats starting at in_offset.
// Define LINE_WORD_SERIALIZER_WRAP_EN for critical-word-first wrapping bursts.
module line_word_serializer
  import lc3b_types::*;
#(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH = 16,
  localparam int unsigned WORDS     = LINE_WIDTH / WORD_WIDTH,
  localparam int unsigned IDXW      = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LINE_WIDTH-1:0] in_line,
  input  logic [IDXW-1:0]       in_offset,
  input  logic                  in_single,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_word,
  output logic [IDXW-1:0]       out_index,
  output logic                  out_last
);

  ser_state_e            state_q, state_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [IDXW:0]         rem_q, rem_d;
  logic                  single_q, single_d;
  logic [IDXW:0]         full_beats;

`ifdef LINE_WORD_SERIALIZER_WRAP_EN
  assign full_beats = (IDXW+1)'(WORDS);
`else
  assign full_beats = (IDXW+1)'(WORDS) - {1'b0, in_offset};
`endif

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    single_d = single_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d  = S_BUSY;
          line_d   = in_line;
          idx_d    = in_offset;
          single_d = in_single;
          rem_d    = in_single ? (IDXW+1)'(1) : full_beats;
        end
      end
      S_BUSY: begin
        if (out_ready) begin
          idx_d = idx_q + IDXW'(1);
          rem_d = rem_q - (IDXW+1)'(1);
          // Final beat: in_ready only rises on the following cycle.
          if (out_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      line_q   <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      single_q <= single_d;
    end
  end

  line_word_select #(
    .LINE_WIDTH(LINE_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_select (
    .line(line_q),
    .idx (idx_q),
    .word(out_word)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_BUSY);
  assign out_index = idx_q;
  assign out_last  = (state_q == S_BUSY) && (single_q || rem_q == (IDXW+1)'(1));

endmodule

// File: tb/tb_line_word_serializer.sv
// Directed self-checking bench for line_word_serializer (8 x 16-bit words per line).
module tb_line_word_serializer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_line;
  logic [2:0]   in_offset;
  logic         in_single;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_word;
  logic [2:0]   out_index;
  logic         out_last;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] L = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [127:0] M = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;

  line_word_serializer #(
    .LINE_WIDTH(128),
    .WORD_WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_line  (in_line),
    .in_offset(in_offset),
    .in_single(in_single),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_index(out_index),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int full_len(input int off);
`ifdef LINE_WORD_SERIALIZER_WRAP_EN
    return 8;
`else
    return 8 - off;
`endif
  endfunction

  task automatic beat_chk(input logic [127:0] line, input int idx, input bit last);
    logic [15:0] w;
    w = line[idx*16 +: 16];
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    chk("out_word", 32'(out_word), 32'(w));
    chk("out_index", 32'(out_index), 32'(idx));
    chk("out_last", 32'(out_last), 32'(last));
  endtask

  task automatic idle_chk();
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Checks beats k0..k1-1 of an n-beat burst, handshaking each with out_ready=1.
  task automatic run_burst(input logic [127:0] line, input int off, input int k0,
                           input int k1, input int n);
    out_ready = 1'b1;
    for (int k = k0; k < k1; k++) begin
      beat_chk(line, (off + k) % 8, k == n - 1);
      step();
    end
    if (k1 == n) idle_chk();
  endtask

  task automatic accept(input logic [127:0] line, input int off, input bit single);
    in_valid  = 1'b1;
    in_line   = line;
    in_offset = 3'(off);
    in_single = single;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_line = '0; in_offset = '0;
    in_single = 1'b0; out_ready = 1'b1;
    #1;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", 32'(out_word), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);

    // Full burst from offset 0.
    accept(L, 0, 1'b0);
    run_burst(L, 0, 0, 8, 8);

    // Offset 5: wraps only when the macro is defined.
    accept(L, 5, 1'b0);
    run_burst(L, 5, 0, full_len(5), full_len(5));

    // Single beat at offset 3.
    accept(L, 3, 1'b1);
    run_burst(L, 3, 0, 1, 1);

    // Backpressure at beat 1111.
    accept(L, 0, 1'b0);
    run_burst(L, 0, 0, 1, 8);
    out_ready = 1'b0;
    repeat (3) begin
      step();
      beat_chk(L, 1, 1'b0);
    end
    run_burst(L, 0, 1, 8, 8);

    // Reset mid-burst, right after beat 3333 handshakes.
    accept(L, 0, 1'b0);
    run_burst(L, 0, 0, 4, 8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    chk("midrst_out_word", 32'(out_word), 32'd0);
    chk("midrst_out_index", 32'(out_index), 32'd0);
    accept(L, 6, 1'b0);
    run_burst(L, 6, 0, full_len(6), full_len(6));

    // in_valid held with new data during BUSY is ignored until IDLE.
    in_valid = 1'b1; in_line = L; in_offset = 3'd0; in_single = 1'b0;
    step();
    in_line = M;
    run_burst(L, 0, 0, 8, 8);
    step();
    in_valid = 1'b0;
    run_burst(M, 0, 0, 8, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
